fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue.sv | 92 +++++++++
 tb/tb_fetch_queue.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Four-entry in-order fetch queue between instruction fetch and decode.
// Define FETCH_QUEUE_BYPASS_EN to let an empty queue forward a push straight to decode.
module fetch_queue (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        push_valid_in,
  input  logic [31:0] push_pc_in,
  input  logic [31:0] push_instr_in,
  output logic        push_ready_out,
  output logic        pop_valid_out,
  output logic [31:0] pop_pc_out,
  output logic [31:0] pop_instr_out,
  output logic [31:0] pop_next_pc_out,
  input  logic        pop_ready_in,
  input  logic        flush_in,
  output logic [2:0]  count_out
);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; flush_in wins over both sides and discards that edge's transfers.

  logic [31:0] pc_mem    [4];
  logic [31:0] instr_mem [4];
  logic [1:0]  wr_ptr;
  logic [1:0]  rd_ptr;
  logic [2:0]  count;

  logic        head_valid;
  logic [31:0] head_pc;
  logic [31:0] head_instr;
  logic        bypass;
  logic        do_push;
  logic        do_pop;

  assign head_valid = (count != 3'd0);
  assign head_pc    = head_valid ? pc_mem[rd_ptr]    : 32'd0;
  assign head_instr = head_valid ? instr_mem[rd_ptr] : 32'd0;

  assign push_ready_out = flush_in | (count != 3'd4);
  assign count_out      = count;

`ifdef FETCH_QUEUE_BYPASS_EN
  // An empty queue presents the offered entry directly to decode.
  assign bypass = ~head_valid & ~flush_in & push_valid_in;
`else
  assign bypass = 1'b0;
`endif

  always_comb begin
    pop_valid_out   = ~flush_in & head_valid;
    pop_pc_out      = head_pc;
    pop_instr_out   = head_instr;
    pop_next_pc_out = head_valid ? head_pc + 32'd4 : 32'd0;
    if (bypass) begin
      pop_valid_out   = 1'b1;
      pop_pc_out      = push_pc_in;
      pop_instr_out   = push_instr_in;
      pop_next_pc_out = push_pc_in + 32'd4;
    end
  end

  // A bypassed entry consumed in the same cycle never touches storage.
  assign do_push = push_valid_in & push_ready_out & ~(bypass & pop_ready_in);
  assign do_pop  = pop_valid_out & pop_ready_in & ~bypass;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      count  <= 3'd0;
      for (int i = 0; i < 4; i++) begin
        pc_mem[i]    <= 32'd0;
        instr_mem[i] <= 32'd0;
      end
    end else if (flush_in) begin
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      count  <= 3'd0;
    end else begin
      if (do_push) begin
        pc_mem[wr_ptr]    <= push_pc_in;
        instr_mem[wr_ptr] <= push_instr_in;
        wr_ptr            <= wr_ptr + 2'd1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 2'd1;
      end
      count <= count + {2'b00, do_push} - {2'b00, do_pop};
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed and randomized bench for fetch_queue against a queue-based reference model.
module tb_fetch_queue;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic        push_valid_in;
  logic [31:0] push_pc_in;
  logic [31:0] push_instr_in;
  logic        push_ready_out;
  logic        pop_valid_out;
  logic [31:0] pop_pc_out;
  logic [31:0] pop_instr_out;
  logic [31:0] pop_next_pc_out;
  logic        pop_ready_in;
  logic        flush_in;
  logic [2:0]  count_out;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  entry_t exp_q[$];

  fetch_queue dut (
    .clk_in          (clk_in),
    .rst_n_in        (rst_n_in),
    .push_valid_in   (push_valid_in),
    .push_pc_in      (push_pc_in),
    .push_instr_in   (push_instr_in),
    .push_ready_out  (push_ready_out),
    .pop_valid_out   (pop_valid_out),
    .pop_pc_out      (pop_pc_out),
    .pop_instr_out   (pop_instr_out),
    .pop_next_pc_out (pop_next_pc_out),
    .pop_ready_in    (pop_ready_in),
    .flush_in        (flush_in),
    .count_out       (count_out)
  );

  // clock / reset
  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle at the falling edge, compare all outputs against the model
  // before the rising edge, then advance the model as that edge will.
  task automatic step(input logic pv, input logic [31:0] pc, input logic [31:0] instr,
                      input logic pr, input logic fl);
    logic        e_ready, e_valid, bypass;
    logic [31:0] e_pc, e_instr, e_next;
    int          n;
    @(negedge clk_in);
    push_valid_in = pv;
    push_pc_in    = pc;
    push_instr_in = instr;
    pop_ready_in  = pr;
    flush_in      = fl;
    #1;
    n       = exp_q.size();
    e_ready = fl || (n != 4);
    e_valid = !fl && (n != 0);
    e_pc    = (n != 0) ? exp_q[0].pc    : 32'd0;
    e_instr = (n != 0) ? exp_q[0].instr : 32'd0;
    e_next  = (n != 0) ? exp_q[0].pc + 32'd4 : 32'd0;
    bypass  = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
    if (n == 0 && !fl && pv) begin
      bypass  = 1'b1;
      e_valid = 1'b1;
      e_pc    = pc;
      e_instr = instr;
      e_next  = pc + 32'd4;
    end
`endif
    check("count", {29'd0, count_out}, n);
    check("push_ready", {31'd0, push_ready_out}, {31'd0, e_ready});
    check("pop_valid", {31'd0, pop_valid_out}, {31'd0, e_valid});
    check("pop_pc", pop_pc_out, e_pc);
    check("pop_instr", pop_instr_out, e_instr);
    check("pop_next_pc", pop_next_pc_out, e_next);
    if (fl) begin
      exp_q.delete();
    end else if (bypass) begin
      if (!pr) exp_q.push_back('{pc, instr});
    end else begin
      if (e_valid && pr) void'(exp_q.pop_front());
      if (pv && e_ready) exp_q.push_back('{pc, instr});
    end
  endtask

  // Idle for one edge and stop just after the next falling edge for state checks.
  task automatic probe();
    @(negedge clk_in);
    push_valid_in = 1'b0;
    pop_ready_in  = 1'b0;
    flush_in      = 1'b0;
    #1;
  endtask

  initial begin
    rst_n_in      = 1'b0;
    push_valid_in = 1'b0;
    push_pc_in    = 32'd0;
    push_instr_in = 32'd0;
    pop_ready_in  = 1'b0;
    flush_in      = 1'b0;
    #2;
    check("rst_count", {29'd0, count_out}, 0);
    check("rst_push_ready", {31'd0, push_ready_out}, 1);
    check("rst_pop_valid", {31'd0, pop_valid_out}, 0);
    check("rst_pop_pc", pop_pc_out, 0);
    check("rst_pop_next_pc", pop_next_pc_out, 0);
    @(negedge clk_in);
    rst_n_in = 1'b1;

    // two pushes while decode stalls
    step(1, 32'h0, 32'h8C010004, 0, 0);
    step(1, 32'h4, 32'h20420001, 0, 0);
    probe();
    check("two_count", {29'd0, count_out}, 2);
    check("two_head_pc", pop_pc_out, 32'h0);
    check("two_next_pc", pop_next_pc_out, 32'h4);
    check("two_head_instr", pop_instr_out, 32'h8C010004);
    step(0, 0, 0, 0, 1);

    // fill past capacity, then drain in order
    for (int i = 0; i < 4; i++) step(1, 32'(i * 4), 32'hA000 + 32'(i), 0, 0);
    step(1, 32'h10, 32'hA004, 0, 0);
    check("full_ready", {31'd0, push_ready_out}, 0);
    probe();
    check("full_count", {29'd0, count_out}, 4);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 1, 0);
      check("drain_pc", pop_pc_out, 32'(i * 4));
    end
    probe();
    check("drain_empty", {29'd0, count_out}, 0);

    // push while full with a pop: pop only; then push+pop holds count
    for (int i = 0; i < 4; i++) step(1, 32'h100 + 32'(i * 4), 32'hB000 + 32'(i), 0, 0);
    step(1, 32'h200, 32'hB100, 1, 0);
    probe();
    check("full_pushpop_count", {29'd0, count_out}, 3);
    step(1, 32'h204, 32'hB101, 1, 0);
    probe();
    check("pushpop_count", {29'd0, count_out}, 3);

    // flush beats a simultaneous push
    step(1, 32'h300, 32'hC000, 1, 1);
    check("flush_valid", {31'd0, pop_valid_out}, 0);
    check("flush_ready", {31'd0, push_ready_out}, 1);
    probe();
    check("flush_count", {29'd0, count_out}, 0);
    check("flush_valid_after", {31'd0, pop_valid_out}, 0);
    step(1, 32'h40, 32'hC001, 0, 0);
    probe();
    check("after_flush_head", pop_pc_out, 32'h40);
    step(0, 0, 0, 1, 0);

    // next-pc wraps, then ten push/pop cycles walk the pointers around
    step(1, 32'hFFFFFFFC, 32'hD000, 0, 0);
    probe();
    check("wrap_next_pc", pop_next_pc_out, 32'h0);
    for (int i = 0; i < 10; i++) step(1, 32'h1000 + 32'(i * 4), 32'hE000 + 32'(i), 1, 0);
    for (int i = 0; i < 2; i++) step(0, 0, 0, 1, 0);

    // bypass or one-cycle latency from an empty queue
    step(0, 0, 0, 0, 1);
    step(1, 32'h100, 32'hF000, 1, 0);
`ifdef FETCH_QUEUE_BYPASS_EN
    check("byp_same_cycle_pc", pop_pc_out, 32'h100);
    probe();
    check("byp_count", {29'd0, count_out}, 0);
`else
    check("nobyp_same_cycle_valid", {31'd0, pop_valid_out}, 0);
    probe();
    check("nobyp_count", {29'd0, count_out}, 1);
    check("nobyp_next_pc", pop_pc_out, 32'h100);
`endif
    step(0, 0, 0, 1, 0);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), {$urandom_range(0, 32'h3FFFFFFF), 2'b00}, $urandom,
           1'($urandom_range(0, 1)), ($urandom_range(0, 19) == 0));
    end

    // asynchronous reset mid-operation
    step(1, 32'h500, 32'h1, 0, 0);
    step(1, 32'h504, 32'h2, 0, 0);
    @(negedge clk_in);
    push_valid_in = 1'b0;
    pop_ready_in  = 1'b0;
    #2 rst_n_in = 1'b0;
    #1;
    check("async_rst_count", {29'd0, count_out}, 0);
    check("async_rst_valid", {31'd0, pop_valid_out}, 0);
    check("async_rst_ready", {31'd0, push_ready_out}, 1);
    check("async_rst_pc", pop_pc_out, 0);
    #1 rst_n_in = 1'b1;
    exp_q.delete();
    step(1, 32'h600, 32'h3, 0, 0);
    step(1, 32'h604, 32'h4, 0, 0);
    probe();
    check("post_rst_head", pop_pc_out, 32'h600);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
